complex_frame_splitter: RTL and testbench

- Sits directly upstream of the sample-to-byte serializer.
- Accepts one complex sample per beat as {imag, real} and forwards the real halves of a frame straight through on the real output stream.
- Stores the imaginary halves in a frame buffer and replays them on the imag output stream once the real half of the frame is complete.
- The serializer therefore sees all real samples, then all imaginary samples, each stream with its own tlast.

---
 rtl/complex_frame_splitter_if.sv | 35 +++
 rtl/complex_frame_splitter.sv | 124 ++++++++++++
 tb/tb_complex_frame_splitter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/complex_frame_splitter_if.sv
// rtl/complex_frame_splitter_if.sv - complex sample input and split real/imag output streams
interface complex_frame_splitter_if #(
  parameter int DATA_W = 32
);
  logic [2*DATA_W-1:0] s_axis_tdata;
  logic                s_axis_tvalid;
  logic                s_axis_tready;
  logic                s_axis_tlast;
  logic [DATA_W-1:0]   m_real_tdata;
  logic                m_real_tvalid;
  logic                m_real_tready;
  logic                m_real_tlast;
  logic [DATA_W-1:0]   m_imag_tdata;
  logic                m_imag_tvalid;
  logic                m_imag_tready;
  logic                m_imag_tlast;

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_real_tdata, m_real_tvalid, m_real_tlast,
    output m_real_tready,
    input  m_imag_tdata, m_imag_tvalid, m_imag_tlast,
    output m_imag_tready
  );

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_real_tdata, m_real_tvalid, m_real_tlast,
    input  m_real_tready,
    output m_imag_tdata, m_imag_tvalid, m_imag_tlast,
    input  m_imag_tready
  );
endinterface

// File: rtl/complex_frame_splitter.sv
// rtl/complex_frame_splitter.sv - passes real halves through, buffers and replays imag halves per frame
module complex_frame_splitter #(
  parameter int FRAME_LEN = 512,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 9
) (
  input  logic clk,
  input  logic rst,
  complex_frame_splitter_if.slave bus,
  output logic err_short,
  output logic err_long
);
  typedef enum logic {FILL, DRAIN} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] WR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   PTR_ONE  = (ADDR_W + 1)'(1);

  state_t state, state_nx;
  logic [ADDR_W-1:0] wr_cnt;
  logic [ADDR_W:0]   frame_len, rd_ptr;
  logic [DATA_W-1:0] mem [FRAME_LEN];
  logic [DATA_W-1:0] rd_data, skid_data;
  logic rd_vld, rd_last, skid_vld, skid_last;
  logic in_fire, close, out_ready, imag_fire, rd_issue, skid_vld_nx;

  assign out_ready = !bus.m_imag_tvalid || bus.m_imag_tready;
  assign imag_fire = bus.m_imag_tvalid && bus.m_imag_tready;
  // A read is only issued if its data is guaranteed a slot (output or skid) when it lands.
  assign skid_vld_nx = out_ready ? (skid_vld && rd_vld) : (skid_vld || rd_vld);

  always_comb begin
    state_nx           = state;
    bus.s_axis_tready  = 1'b0;
    bus.m_real_tvalid  = 1'b0;
    bus.m_real_tlast   = 1'b0;
    bus.m_real_tdata   = bus.s_axis_tdata[DATA_W-1:0];
    in_fire            = 1'b0;
    close              = 1'b0;
    rd_issue           = 1'b0;
    case (state)
      FILL: begin
        bus.s_axis_tready = bus.m_real_tready;
        bus.m_real_tvalid = bus.s_axis_tvalid;
        close             = bus.s_axis_tvalid && (bus.s_axis_tlast || wr_cnt == LAST_IDX);
        bus.m_real_tlast  = close;
        in_fire           = bus.s_axis_tvalid && bus.m_real_tready;
        if (in_fire && close) state_nx = DRAIN;
      end
      DRAIN: begin
        rd_issue = (rd_ptr < frame_len) && !skid_vld_nx;
        if (imag_fire && bus.m_imag_tlast) state_nx = FILL;
      end
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (in_fire) mem[wr_cnt] <= bus.s_axis_tdata[2*DATA_W-1:DATA_W];
  end

  always_ff @(posedge clk) begin
    if (rd_issue) rd_data <= mem[rd_ptr[ADDR_W-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= FILL;
      wr_cnt            <= '0;
      rd_ptr            <= '0;
      frame_len         <= '0;
      rd_vld            <= 1'b0;
      rd_last           <= 1'b0;
      skid_vld          <= 1'b0;
      skid_last         <= 1'b0;
      skid_data         <= '0;
      bus.m_imag_tvalid <= 1'b0;
      bus.m_imag_tlast  <= 1'b0;
      bus.m_imag_tdata  <= '0;
      err_short         <= 1'b0;
      err_long          <= 1'b0;
    end else begin
      state     <= state_nx;
      err_short <= in_fire && bus.s_axis_tlast && (wr_cnt != LAST_IDX);
      err_long  <= in_fire && !bus.s_axis_tlast && (wr_cnt == LAST_IDX);
      if (in_fire) begin
        if (close) begin
          frame_len <= {1'b0, wr_cnt} + PTR_ONE;
          wr_cnt    <= '0;
        end else begin
          wr_cnt <= wr_cnt + WR_ONE;
        end
      end
      rd_vld   <= rd_issue;
      skid_vld <= skid_vld_nx;
      if (rd_issue) begin
        rd_ptr  <= rd_ptr + PTR_ONE;
        rd_last <= (rd_ptr == frame_len - PTR_ONE);
      end
      if (out_ready) begin
        bus.m_imag_tvalid <= skid_vld || rd_vld;
        if (skid_vld) begin
          bus.m_imag_tdata <= skid_data;
          bus.m_imag_tlast <= skid_last;
        end else if (rd_vld) begin
          bus.m_imag_tdata <= rd_data;
          bus.m_imag_tlast <= rd_last;
        end
        if (skid_vld && rd_vld) begin
          skid_data <= rd_data;
          skid_last <= rd_last;
        end
      end else if (rd_vld) begin
        skid_data <= rd_data;
        skid_last <= rd_last;
      end
      if (imag_fire && bus.m_imag_tlast) begin
        rd_ptr            <= '0;
        bus.m_imag_tvalid <= 1'b0;
        bus.m_imag_tlast  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_complex_frame_splitter.sv
// tb/tb_complex_frame_splitter.sv - randomized bench for complex_frame_splitter with frame-level reference model
module tb_complex_frame_splitter;
  localparam int FL = 512;
  localparam int DW = 32;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] im;
    logic [DW-1:0] re;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic err_short, err_long;
  always #5 clk = ~clk;

  complex_frame_splitter_if #(.DATA_W(DW)) bus ();
  complex_frame_splitter #(.FRAME_LEN(FL), .DATA_W(DW), .ADDR_W(9)) dut (
    .clk(clk), .rst(rst), .bus(bus), .err_short(err_short), .err_long(err_long)
  );

  int passed = 0;
  int total  = 0;

  beat_t src_q[$];
  bit s_acc = 0;
  int bp = 0;

  logic [DW:0] real_q[$], imag_q[$];
  logic [DW:0] exp_real[$], exp_imag[$];
  int n_short = 0, n_long = 0, exp_short = 0, exp_long = 0;
  bit draining = 0;
  bit prev_iv = 0, prev_ir = 0, prev_il = 0;
  logic [DW-1:0] prev_id = '0;
  int cyc = 0, il_cyc = 0, gap = -1;
  bit gap_pending = 0;

  task automatic chk(input string tag, input logic [DW+1:0] obs, input logic [DW+1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin : driver
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tlast  = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (s_acc && src_q.size() > 0) void'(src_q.pop_front());
      s_acc = 0;
      if (src_q.size() > 0) begin
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = {src_q[0].im, src_q[0].re};
        bus.s_axis_tlast  = src_q[0].last;
      end else begin
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
      end
    end
  end

  initial begin : ready_gen
    bus.m_real_tready = 1'b1;
    bus.m_imag_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.m_real_tready = ($urandom_range(0, 99) >= bp);
      bus.m_imag_tready = ($urandom_range(0, 99) >= bp);
    end
  end

  always @(negedge clk) begin
    cyc++;
    s_acc = !rst && bus.s_axis_tvalid && bus.s_axis_tready;
    if (!rst) begin
      if (draining)
        chk("drain_stall", {bus.s_axis_tready, bus.m_real_tvalid}, 0);
      else begin
        chk("fill_pass", {bus.s_axis_tready, bus.m_real_tvalid, bus.m_imag_tvalid},
            {bus.m_real_tready, bus.s_axis_tvalid, 1'b0});
        if (bus.s_axis_tvalid)
          chk("real_data", bus.m_real_tdata, bus.s_axis_tdata[DW-1:0]);
      end
      if (prev_iv && !prev_ir)
        chk("imag_hold", {bus.m_imag_tvalid, bus.m_imag_tlast, bus.m_imag_tdata}, {1'b1, prev_il, prev_id});
      if (bus.m_real_tvalid && bus.m_real_tready) begin
        real_q.push_back({bus.m_real_tlast, bus.m_real_tdata});
        if (gap_pending) begin gap = cyc - il_cyc; gap_pending = 0; end
        if (bus.m_real_tlast) draining = 1;
      end
      if (bus.m_imag_tvalid && bus.m_imag_tready) begin
        imag_q.push_back({bus.m_imag_tlast, bus.m_imag_tdata});
        if (bus.m_imag_tlast) begin draining = 0; il_cyc = cyc; gap_pending = 1; end
      end
      if (err_short) n_short++;
      if (err_long) n_long++;
      prev_iv = bus.m_imag_tvalid; prev_ir = bus.m_imag_tready;
      prev_il = bus.m_imag_tlast;  prev_id = bus.m_imag_tdata;
    end else begin
      prev_iv = 0;
    end
  end

  // Reference: frames close on tlast or on the FRAME_LEN-th beat; imag replays only for closed frames.
  task automatic model(input beat_t b[$]);
    int c = 0;
    logic [DW-1:0] fr[$];
    exp_real.delete(); exp_imag.delete(); exp_short = 0; exp_long = 0;
    foreach (b[i]) begin
      bit cl = b[i].last || (c == FL - 1);
      exp_real.push_back({cl, b[i].re});
      fr.push_back(b[i].im);
      if (b[i].last && c < FL - 1) exp_short++;
      if (!b[i].last && c == FL - 1) exp_long++;
      if (cl) begin
        foreach (fr[k]) exp_imag.push_back({k == fr.size() - 1, fr[k]});
        fr.delete();
        c = 0;
      end else c++;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    src_q.delete(); s_acc = 0; bus.s_axis_tvalid = 1'b0; bus.s_axis_tlast = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    real_q.delete(); imag_q.delete();
    n_short = 0; n_long = 0; draining = 0; gap_pending = 0; gap = -1;
  endtask

  task automatic run_case(input string tag, input beat_t b[$]);
    int t = 0;
    model(b);
    foreach (b[i]) src_q.push_back(b[i]);
    while ((real_q.size() < exp_real.size() || imag_q.size() < exp_imag.size()) && t < 8000) begin
      @(negedge clk); t++;
    end
    if (t >= 8000) chk({tag, "_timeout"}, 0, 1);
    repeat (10) @(negedge clk);
    chk({tag, "_real_n"}, real_q.size(), exp_real.size());
    chk({tag, "_imag_n"}, imag_q.size(), exp_imag.size());
    for (int i = 0; i < exp_real.size() && i < real_q.size(); i++)
      chk({tag, "_real"}, real_q[i], exp_real[i]);
    for (int i = 0; i < exp_imag.size() && i < imag_q.size(); i++)
      chk({tag, "_imag"}, imag_q[i], exp_imag[i]);
    chk({tag, "_err"}, {n_short[7:0], n_long[7:0]}, {exp_short[7:0], exp_long[7:0]});
  endtask

  function automatic beat_t rnd_beat(input bit last);
    beat_t x;
    x.re = $urandom; x.im = $urandom; x.last = last;
    return x;
  endfunction

  initial begin : main
    beat_t b[$];
    int t;
    rst = 1'b1;
    bp = 0;
    do_reset();
    @(negedge clk);
    chk("reset_out", {bus.m_imag_tvalid, bus.m_imag_tlast, err_short, err_long}, 0);
    chk("reset_data", bus.m_imag_tdata, 0);
    chk("reset_rdy", bus.s_axis_tready, bus.m_real_tready);

    for (int i = 0; i < FL; i++) b.push_back({i == FL - 1, 32'h8000_0000 | i, 32'(i)});
    run_case("nominal", b);

    do_reset(); bp = 50;
    run_case("backpressure", b);

    do_reset(); bp = 0; b.delete();
    for (int i = 0; i < 8; i++) b.push_back(rnd_beat(i == 7));
    run_case("short", b);

    do_reset(); b.delete();
    for (int i = 0; i < 600; i++) b.push_back(rnd_beat(1'b0));
    run_case("long", b);

    do_reset(); b.delete();
    for (int i = 0; i < 2 * FL; i++) b.push_back(rnd_beat(i % FL == FL - 1));
    run_case("b2b", b);
    chk("b2b_gap", gap, 1);

    do_reset(); b.delete();
    for (int i = 0; i < FL; i++) b.push_back(rnd_beat(i == FL - 1));
    foreach (b[i]) src_q.push_back(b[i]);
    t = 0;
    while (imag_q.size() < 100 && t < 3000) begin @(negedge clk); t++; end
    if (t >= 3000) chk("middrain_timeout", 0, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    src_q.delete(); s_acc = 0; bus.s_axis_tvalid = 1'b0; bus.s_axis_tlast = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("middrain_rst", {bus.m_imag_tvalid, err_short, err_long}, 0);
    chk("middrain_rdy", bus.s_axis_tready, bus.m_real_tready);
    #1;
    rst = 1'b0;
    real_q.delete(); imag_q.delete(); n_short = 0; n_long = 0; draining = 0;
    b.delete();
    for (int i = 0; i < 4; i++) b.push_back(rnd_beat(i == 3));
    run_case("after_rst", b);
    repeat (20) @(negedge clk);
    chk("after_rst_quiet", imag_q.size(), 4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
